imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 25 ++
 rtl/imem_responder.sv | 132 +++++++++++++
 tb/tb_imem_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side handshake between an instruction fetch unit (master) and the
// instruction memory responder (slave).
interface imem_responder_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_err;

    modport master (
        output imem_valid,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready,
        input  imem_err
    );

    modport slave (
        input  imem_valid,
        input  imem_addr,
        output imem_rdata,
        output imem_ready,
        output imem_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word-addressed program store with a fixed
// wait-state count per fetch and a side port for program loading.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    imem_responder_if.slave                imem,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [31:0]                    load_data,
    output logic                           busy
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        capture;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [31:0] byte_off;
    logic [31:0] word_off;
    logic        rd_err;
    logic [31:0] mem_word;

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the program store is deliberately left out of reset so a loaded
    // image survives a core reset; it also keeps it mappable onto RAM macros.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // NOTE: every signal driven here gets its default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        capture    = 1'b0;
        enter_resp = 1'b0;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (imem.imem_valid) begin
                    capture    = 1'b1;
                    addr_d     = imem.imem_addr;
                    wait_cnt_d = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the array is read on the capture edge itself,
    // so the live bus address is used instead of the captured copy.
    always_comb begin
        rd_addr  = capture ? imem.imem_addr : addr_q;
        byte_off = rd_addr - BASE_ADDR;
        word_off = byte_off >> 2;
        rd_err   = (rd_addr[1:0] != 2'b00) ||
                   (rd_addr < BASE_ADDR)   ||
                   (word_off >= 32'(DEPTH_WORDS));
        mem_word = mem[word_off[IDX_W-1:0]];

        ready_d = enter_resp;
        err_d   = enter_resp && rd_err;
        rdata_d = rdata_q;
        if (enter_resp) begin
            rdata_d = rd_err ? NOP_WORD : mem_word;
        end
    end

    // NOTE: state uses non-blocking assignments so a same-edge load write to
    // the array is not yet visible to the response read (read-first).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'd0;
            rdata_q    <= NOP_WORD;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign imem.imem_rdata = rdata_q;
    assign imem.imem_ready = ready_q;
    assign imem.imem_err   = err_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder across four parameterisations that
// share one clock and one program-load bus.
module tb_imem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock;
    logic        rst_n;
    logic        rst2_n;
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;
    logic [3:0]  busy;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    imem_responder_if if0 ();
    imem_responder_if if3 ();
    imem_responder_if ifb ();
    imem_responder_if if2 ();

    imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset_n(rst_n), .imem(if0.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[0])
    );
    imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset_n(rst_n), .imem(if3.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[1])
    );
    imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .WAIT_STATES(0)) u_base (
        .clock(clock), .reset_n(rst_n), .imem(ifb.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[2])
    );
    imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
        .clock(clock), .reset_n(rst2_n), .imem(if2.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[3])
    );

    logic [3:0]  rdy;
    logic [3:0]  er;
    logic [31:0] rd [4];

    assign rdy   = {if2.imem_ready, ifb.imem_ready, if3.imem_ready, if0.imem_ready};
    assign er    = {if2.imem_err, ifb.imem_err, if3.imem_err, if0.imem_err};
    assign rd[0] = if0.imem_rdata;
    assign rd[1] = if3.imem_rdata;
    assign rd[2] = ifb.imem_rdata;
    assign rd[3] = if2.imem_rdata;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Every ready pulse consumes exactly one expected response.
    always @(negedge clock) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready inst=%0d rdata=%h err=%b, required no response",
                             i, rd[i], er[i]);
                end else begin
                    e = sb_q.pop_front();
                    if (rd[i] !== e.data || er[i] !== e.err) begin
                        failures++;
                        $display("FAIL response inst=%0d got rdata=%h err=%b, required rdata=%h err=%b",
                                 i, rd[i], er[i], e.data, e.err);
                    end
                end
            end else if (er[i] !== 1'b0) begin
                failures++;
                $display("FAIL err_outside_resp inst=%0d got err=%b, required 0", i, er[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] a);
        case (sel)
            0: begin if0.imem_valid = v; if0.imem_addr = a; end
            1: begin if3.imem_valid = v; if3.imem_addr = a; end
            2: begin ifb.imem_valid = v; ifb.imem_addr = a; end
            default: begin if2.imem_valid = v; if2.imem_addr = a; end
        endcase
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic fetch(input int sel, input logic [31:0] addr,
                         input logic [31:0] data, input logic err);
        sb_q.push_back('{data: data, err: err});
        drive(sel, 1'b1, addr);
        tick();
        drive(sel, 1'b0, addr);
        wait_drain("fetch");
        tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            checks += 4;
            if (rdy[i] !== 1'b0) begin failures++; $display("FAIL reset_ready inst=%0d got %b, required 0", i, rdy[i]); end
            if (er[i] !== 1'b0) begin failures++; $display("FAIL reset_err inst=%0d got %b, required 0", i, er[i]); end
            if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy inst=%0d got %b, required 0", i, busy[i]); end
            if (rd[i] !== 32'h13) begin failures++; $display("FAIL reset_rdata inst=%0d got %h, required 00000013", i, rd[i]); end
        end
        @(posedge clock);
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        // A misaligned fetch on the very first edge gives a known response.
        sb_q.push_back('{data: 32'h13, err: 1'b1});
        drive(0, 1'b1, 32'h3);
        tick();
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL first_capture got ready=%b, required 1", rdy[0]);
        end
        drive(0, 1'b0, 32'h0);
        wait_drain("first_capture");
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        sb_q.push_back('{data: words[0], err: 1'b0});
        drive(0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rdy[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready beat=%0d got %b, required 1", i, rdy[0]);
            end
            if (i < 3) begin
                drive(0, 1'b1, 32'((i + 1) * 4));
                sb_q.push_back('{data: words[i+1], err: 1'b0});
            end else begin
                drive(0, 1'b0, 32'h0);
            end
        end
        tick();
        checks++;
        if (rdy[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got ready=%b busy=%b, required 0 0", rdy[0], busy[0]);
        end
        wait_drain("b2b");
    endtask

    task automatic test_wait_states();
        sb_q.push_back('{data: 32'h33, err: 1'b0});
        drive(1, 1'b1, 32'h8);
        tick();
        drive(1, 1'b0, 32'h40);
        for (int k = 1; k <= 5; k++) begin
            checks += 2;
            if (busy[1] !== (k <= 4)) begin
                failures++;
                $display("FAIL ws3_busy cycle=%0d got %b, required %b", k, busy[1], (k <= 4));
            end
            if (rdy[1] !== (k == 4)) begin
                failures++;
                $display("FAIL ws3_ready cycle=%0d got %b, required %b", k, rdy[1], (k == 4));
            end
            if (k < 5) tick();
        end
        wait_drain("ws3");
    endtask

    task automatic test_errors();
        fetch(0, 32'h0000_0002, 32'h13, 1'b1);
        fetch(0, 32'h0000_1000, 32'h13, 1'b1);
        fetch(0, 32'h0000_0FFC, 32'h0FFC_0FFC, 1'b0);
        fetch(2, 32'h0000_00FC, 32'h13, 1'b1);
        fetch(2, 32'h0000_0000, 32'h13, 1'b1);
        fetch(2, 32'h0000_0100, 32'h11, 1'b0);
        fetch(2, 32'h0000_0101, 32'h13, 1'b1);
    endtask

    task automatic test_collision();
        sb_q.push_back('{data: 32'h5555, err: 1'b0});
        drive(0, 1'b1, 32'h14);
        load_en   = 1'b1;
        load_idx  = 10'd5;
        load_data = 32'hAAAA_0000;
        tick();
        load_en = 1'b0;
        drive(0, 1'b0, 32'h0);
        wait_drain("collision");
        tick();
        fetch(0, 32'h14, 32'hAAAA_0000, 1'b0);
    endtask

    task automatic test_reset_wait();
        bit seen;
        fetch(3, 32'h0, 32'h11, 1'b0);
        drive(3, 1'b1, 32'h8);
        tick();
        drive(3, 1'b0, 32'h0);
        checks++;
        if (busy[3] !== 1'b1) begin
            failures++;
            $display("FAIL rw_busy_before got %b, required 1", busy[3]);
        end
        #2 rst2_n = 1'b0;
        #1;
        checks += 4;
        if (rdy[3] !== 1'b0) begin failures++; $display("FAIL rw_ready got %b, required 0", rdy[3]); end
        if (er[3] !== 1'b0) begin failures++; $display("FAIL rw_err got %b, required 0", er[3]); end
        if (busy[3] !== 1'b0) begin failures++; $display("FAIL rw_busy got %b, required 0", busy[3]); end
        if (rd[3] !== 32'h13) begin failures++; $display("FAIL rw_rdata got %h, required 00000013", rd[3]); end
        @(posedge clock);
        #4 rst2_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdy[3] !== 1'b0 || busy[3] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rw_no_response got activity after reset, required none");
        end
        fetch(3, 32'h8, 32'h33, 1'b0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        load_en   = 1'b0;
        load_idx  = 10'd0;
        load_data = 32'd0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        drive(2, 1'b0, 32'h0);
        drive(3, 1'b0, 32'h0);

        test_reset();
        load(10'd0, 32'h11);
        load(10'd1, 32'h22);
        load(10'd2, 32'h33);
        load(10'd3, 32'h44);
        load(10'd5, 32'h5555);
        load(10'd16, 32'hDEAD_BEEF);
        load(10'd1023, 32'h0FFC_0FFC);
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_collision();
        test_reset_wait();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
